program_mem_arbiter: RTL and testbench

//  Shares the single program-memory read channel between NUM_CONSUMERS core fetch paths (I-cache miss ports).

---
 rtl/program_mem_arbiter.sv | 128 ++++++++++++
 tb/tb_program_mem_arbiter.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/program_mem_arbiter.sv
// Round-robin arbiter sharing one program-memory read channel among several fetch ports.
// One transaction in flight at a time: IDLE -> WAIT -> RESPOND -> IDLE, all outputs registered.
module program_mem_arbiter #(
  parameter int NUM_CONSUMERS = 4,
  parameter int ADDR_BITS     = 8,
  parameter int DATA_BITS     = 16,
  localparam int GW = (NUM_CONSUMERS > 1) ? $clog2(NUM_CONSUMERS) : 1
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic [NUM_CONSUMERS-1:0]           consumer_read_valid,
  input  logic [NUM_CONSUMERS*ADDR_BITS-1:0] consumer_read_address,
  output logic [NUM_CONSUMERS-1:0]           consumer_read_ready,
  output logic [NUM_CONSUMERS*DATA_BITS-1:0] consumer_read_data,
  output logic                               mem_read_valid,
  output logic [ADDR_BITS-1:0]               mem_read_address,
  input  logic                               mem_read_ready,
  input  logic [DATA_BITS-1:0]               mem_read_data,
  output logic                               busy,
  output logic [GW-1:0]                      grant_id
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_WAIT    = 2'd1,
    S_RESPOND = 2'd2
  } state_e;

  state_e                             state_q, state_d;
  logic [GW-1:0]                      last_grant_q, last_grant_d;
  logic [GW-1:0]                      grant_id_q, grant_id_d;
  logic                               mem_valid_q, mem_valid_d;
  logic [ADDR_BITS-1:0]               mem_addr_q, mem_addr_d;
  logic [NUM_CONSUMERS-1:0]           ready_q, ready_d;
  logic [NUM_CONSUMERS*DATA_BITS-1:0] data_q, data_d;
  logic                               busy_q, busy_d;

  logic                               pick_found;
  logic [GW-1:0]                      pick_idx;
  logic [ADDR_BITS-1:0]               pick_addr;
  int                                 cand;

  // Scan starting one past the last winner so every port gets a turn within N grants.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    pick_addr  = '0;
    cand       = 0;
    for (int k = 1; k <= NUM_CONSUMERS; k++) begin
      cand = (int'(last_grant_q) + k) % NUM_CONSUMERS;
      if (!pick_found && consumer_read_valid[cand]) begin
        pick_found = 1'b1;
        pick_idx   = GW'(cand);
        pick_addr  = consumer_read_address[cand*ADDR_BITS +: ADDR_BITS];
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    grant_id_d   = grant_id_q;
    mem_valid_d  = mem_valid_q;
    mem_addr_d   = mem_addr_q;
    ready_d      = ready_q;
    data_d       = data_q;
    busy_d       = busy_q;
    unique case (state_q)
      S_IDLE: begin
        if (pick_found) begin
          mem_addr_d   = pick_addr;
          grant_id_d   = pick_idx;
          last_grant_d = pick_idx;
          mem_valid_d  = 1'b1;
          busy_d       = 1'b1;
          state_d      = S_WAIT;
        end
      end
      S_WAIT: begin
        if (mem_read_ready) begin
          data_d[int'(grant_id_q)*DATA_BITS +: DATA_BITS] = mem_read_data;
          ready_d[grant_id_q] = 1'b1;
          mem_valid_d         = 1'b0;
          state_d             = S_RESPOND;
        end
      end
      S_RESPOND: begin
        ready_d = '0;
        data_d  = '0;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      last_grant_q <= GW'(NUM_CONSUMERS - 1);
      grant_id_q   <= '0;
      mem_valid_q  <= 1'b0;
      mem_addr_q   <= '0;
      ready_q      <= '0;
      data_q       <= '0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      grant_id_q   <= grant_id_d;
      mem_valid_q  <= mem_valid_d;
      mem_addr_q   <= mem_addr_d;
      ready_q      <= ready_d;
      data_q       <= data_d;
      busy_q       <= busy_d;
    end
  end

  assign consumer_read_ready = ready_q;
  assign consumer_read_data  = data_q;
  assign mem_read_valid      = mem_valid_q;
  assign mem_read_address    = mem_addr_q;
  assign busy                = busy_q;
  assign grant_id            = grant_id_q;

endmodule

// File: tb/tb_program_mem_arbiter.sv
// Bench for program_mem_arbiter: directed scenarios followed by randomized traffic
// checked against a transaction-level round-robin model.
module tb_program_mem_arbiter;
  localparam int N  = 4;
  localparam int A  = 8;
  localparam int D  = 16;
  localparam int GW = 2;

  logic             clk = 1'b0;
  logic             reset;
  logic [N-1:0]     cv;
  logic [N*A-1:0]   ca;
  logic [N-1:0]     consumer_read_ready;
  logic [N*D-1:0]   consumer_read_data;
  logic             mem_read_valid;
  logic [A-1:0]     mem_read_address;
  logic             mrr;
  logic [D-1:0]     mrd;
  logic             busy;
  logic [GW-1:0]    grant_id;

  int checks = 0;
  int errors = 0;

  // Reference model: pending set, requested addresses and the last winner.
  logic [N-1:0] pend;
  logic [A-1:0] addr_m [N];
  int           last_m;
  int           waitc [N];

  program_mem_arbiter #(.NUM_CONSUMERS(N), .ADDR_BITS(A), .DATA_BITS(D)) dut (
    .clk                   (clk),
    .reset                 (reset),
    .consumer_read_valid   (cv),
    .consumer_read_address (ca),
    .consumer_read_ready   (consumer_read_ready),
    .consumer_read_data    (consumer_read_data),
    .mem_read_valid        (mem_read_valid),
    .mem_read_address      (mem_read_address),
    .mem_read_ready        (mrr),
    .mem_read_data         (mrd),
    .busy                  (busy),
    .grant_id              (grant_id)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive();
    cv = pend;
    for (int i = 0; i < N; i++) ca[i*A +: A] = addr_m[i];
  endtask

  function automatic int rr_pick();
    for (int k = 1; k <= N; k++) begin
      if (pend[(last_m + k) % N]) return (last_m + k) % N;
    end
    return -1;
  endfunction

  task automatic chk_idle_zero(input string tag);
    chk({tag, "_ready"}, consumer_read_ready, 0);
    chk({tag, "_data"}, consumer_read_data, 0);
    chk({tag, "_mvalid"}, mem_read_valid, 0);
    chk({tag, "_busy"}, busy, 0);
  endtask

  // One complete transaction starting from IDLE; returns the grant_id the DUT showed.
  task automatic run_txn(input int lat, input logic [D-1:0] rdata, input bit wiggle,
                         input logic [A-1:0] wig_addr, output int got_g);
    int g;
    logic [A-1:0] a_lat;
    logic [N*D-1:0] exp_data;
    g = rr_pick();
    got_g = -1;
    if (g < 0) begin
      checks++;
      errors++;
      $error("FAIL no_pending observed=none expected=request");
      return;
    end
    last_m = g;
    drive();
    tick();
    chk("mem_valid_up", mem_read_valid, 1);
    chk("busy_up", busy, 1);
    chk("grant", grant_id, g);
    chk("mem_addr", mem_read_address, addr_m[g]);
    got_g = int'(grant_id);
    a_lat = addr_m[g];
    for (int i = 0; i < lat; i++) begin
      if (wiggle) ca[g*A +: A] = wig_addr;
      tick();
      chk("wait_valid", mem_read_valid, 1);
      chk("wait_addr", mem_read_address, a_lat);
      chk("wait_ready", consumer_read_ready, 0);
    end
    mrr = 1'b1;
    mrd = rdata;
    tick();
    mrr = 1'b0;
    mrd = D'($urandom);
    exp_data = '0;
    exp_data[g*D +: D] = rdata;
    chk("ready_pulse", consumer_read_ready, 64'(1) << g);
    chk("ready_data", consumer_read_data, exp_data);
    chk("mem_valid_down", mem_read_valid, 0);
    pend[g] = 1'b0;
    drive();
    tick();
    chk("ready_clear", consumer_read_ready, 0);
    chk("data_clear", consumer_read_data, 0);
    chk("busy_down", busy, 0);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    pend = '0;
    mrr = 1'b0;
    drive();
    tick();
    tick();
    chk_idle_zero("reset");
    chk("reset_grant", grant_id, 0);
    chk("reset_addr", mem_read_address, 0);
    reset = 1'b1;
    last_m = N - 1;
  endtask

  initial begin
    int g;
    int order [5];
    int exp_order [5];
    logic [N-1:0] snap;
    logic [N-1:0] newreq;
    exp_order = '{0, 1, 2, 3, 0};
    reset = 1'b0;
    mrr = 1'b0;
    mrd = '0;
    pend = '0;
    for (int i = 0; i < N; i++) begin
      addr_m[i] = '0;
      waitc[i] = 0;
    end
    drive();

    // Reset then a lone request from port 2.
    do_reset();
    pend[2] = 1'b1;
    addr_m[2] = 8'h55;
    run_txn(1, 16'h1234, 1'b0, 8'h00, g);
    chk("first_grant_port2", g, 2);

    // Single request, three-cycle memory latency.
    pend[1] = 1'b1;
    addr_m[1] = 8'h2A;
    run_txn(3, 16'hBEEF, 1'b0, 8'h00, g);
    chk("single_port1", g, 1);

    // Contention from reset state, port 0 re-requests after its turn.
    do_reset();
    pend = '1;
    for (int i = 0; i < N; i++) addr_m[i] = A'(8'h40 + i);
    for (int t = 0; t < 5; t++) begin
      run_txn(t % 2, D'($urandom), 1'b0, 8'h00, order[t]);
      if (t == 0) pend[0] = 1'b1;
    end
    for (int t = 0; t < 5; t++) chk("rr_order", order[t], exp_order[t]);

    // Address changes while waiting must not reach memory.
    pend[3] = 1'b1;
    addr_m[3] = 8'h10;
    run_txn(3, 16'hCAFE, 1'b1, 8'h20, g);

    // Stray strobe while idle, then a strobe on the first WAIT cycle.
    mrr = 1'b1;
    mrd = 16'hDEAD;
    tick();
    tick();
    mrr = 1'b0;
    chk_idle_zero("stray");
    pend[0] = 1'b1;
    addr_m[0] = 8'h77;
    run_txn(0, 16'hA5A5, 1'b0, 8'h00, g);

    // Reset during WAIT drops the transaction and any late response.
    pend = '0;
    pend[2] = 1'b1;
    addr_m[2] = 8'h99;
    drive();
    tick();
    chk("mid_wait_valid", mem_read_valid, 1);
    chk("mid_wait_grant", grant_id, 2);
    tick();
    reset = 1'b0;
    pend = '0;
    drive();
    tick();
    reset = 1'b1;
    last_m = N - 1;
    chk_idle_zero("mid_reset");
    chk("mid_reset_grant", grant_id, 0);
    mrr = 1'b1;
    mrd = 16'hFFFF;
    tick();
    mrr = 1'b0;
    chk("late_ready_1", consumer_read_ready, 0);
    tick();
    chk("late_ready_2", consumer_read_ready, 0);
    chk("late_busy", busy, 0);

    // Randomized traffic against the round-robin model, with a starvation bound.
    for (int i = 0; i < N; i++) waitc[i] = 0;
    for (int it = 0; it < 40; it++) begin
      newreq = N'($urandom_range(0, (1 << N) - 1));
      for (int i = 0; i < N; i++) begin
        if (newreq[i] && !pend[i]) begin
          pend[i] = 1'b1;
          addr_m[i] = A'($urandom);
          waitc[i] = 0;
        end
      end
      if (pend == '0) begin
        g = $urandom_range(0, N - 1);
        pend[g] = 1'b1;
        addr_m[g] = A'($urandom);
        waitc[g] = 0;
      end
      snap = pend;
      run_txn($urandom_range(0, 3), D'($urandom), 1'($urandom_range(0, 1)), A'($urandom), g);
      if (g >= 0) begin
        for (int i = 0; i < N; i++) if (snap[i] && i != g) waitc[i]++;
        chk("no_starve", waitc[g] <= N - 1, 1);
        waitc[g] = 0;
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
